// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the IF/MEM SRAM arbiter: FSM states, owner encoding and
// the per-access request record captured at grant time.
package sram_bus_arbiter_pkg;

  localparam int REG_W = 32;
  localparam int BE_W  = 4;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_HOLD   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e           owner;
    logic             we;
    logic [BE_W-1:0]  be_n;
    logic [REG_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Requester-side handshakes and SRAM pin bundle; signal suffixes are seen
// from the arbiter (slave) side.
interface sram_bus_arbiter_if #(parameter int SRAM_AW = 20);
  logic               if_ce_i;
  logic [31:0]        if_addr_i;
  logic [31:0]        if_data_o;
  logic               if_ready_o;
  logic               mem_ce_i;
  logic               mem_we_i;
  logic [31:0]        mem_addr_i;
  logic [3:0]         mem_sel_i;
  logic [31:0]        mem_data_i;
  logic [31:0]        mem_data_o;
  logic               mem_ready_o;
  logic               stallreq_o;
  logic [SRAM_AW-1:0] sram_addr_o;
  logic [31:0]        sram_wdata_o;
  logic [31:0]        sram_rdata_i;
  logic               sram_ce_n_o;
  logic               sram_oe_n_o;
  logic               sram_we_n_o;
  logic [3:0]         sram_be_n_o;
  logic               sram_dout_en_o;

  modport slave (
    input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i,
           mem_data_i, sram_rdata_i,
    output if_data_o, if_ready_o, mem_data_o, mem_ready_o, stallreq_o,
           sram_addr_o, sram_wdata_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
           sram_be_n_o, sram_dout_en_o
  );

  modport master (
    output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i,
           mem_data_i, sram_rdata_i,
    input  if_data_o, if_ready_o, mem_data_o, mem_ready_o, stallreq_o,
           sram_addr_o, sram_wdata_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
           sram_be_n_o, sram_dout_en_o
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-requester arbiter for one async SRAM. Each access runs
// SETUP -> ACCESS (WAIT_CYCLES) -> HOLD; MEM has fixed priority over IF.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic clk,
  input  logic rst,
  sram_bus_arbiter_if.slave bus
);

  arb_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  arb_req_t           req_q, req_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [REG_W-1:0]   if_data_q, if_data_d;
  logic [REG_W-1:0]   mem_data_q, mem_data_d;

  logic               mem_req, if_req;
  arb_req_t           grant_req;
  logic [SRAM_AW-1:0] grant_addr;

  // In HOLD the current owner still has ce high while seeing ready; mask it
  // so it is not granted a second time.
  assign mem_req = bus.mem_ce_i & ~(state_q == ARB_HOLD && req_q.owner == OWN_MEM);
  assign if_req  = bus.if_ce_i  & ~(state_q == ARB_HOLD && req_q.owner == OWN_IF);

  always_comb begin
    grant_req  = req_q;
    grant_addr = bus.if_addr_i[SRAM_AW+1:2];
    if (mem_req) begin
      grant_req.owner = OWN_MEM;
      grant_req.we    = bus.mem_we_i;
      grant_req.be_n  = bus.mem_we_i ? ~bus.mem_sel_i : 4'b0000;
      grant_req.wdata = bus.mem_data_i;
      grant_addr      = bus.mem_addr_i[SRAM_AW+1:2];
    end else begin
      grant_req.owner = OWN_IF;
      grant_req.we    = 1'b0;
      grant_req.be_n  = 4'b0000;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    case (state_q)
      ARB_IDLE, ARB_HOLD: begin
        state_d = ARB_IDLE;
        if (mem_req || if_req) begin
          state_d = ARB_SETUP;
          req_d   = grant_req;
          addr_d  = grant_addr;
        end
      end
      ARB_SETUP: begin
        state_d = ARB_ACCESS;
        cnt_d   = 3'(WAIT_CYCLES - 1);
      end
      ARB_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = ARB_HOLD;
          if (!req_q.we) begin
            if (req_q.owner == OWN_MEM) mem_data_d = bus.sram_rdata_i;
            else                        if_data_d  = bus.sram_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      req_q      <= '{owner: OWN_IF, we: 1'b0, be_n: 4'b1111, wdata: ZERO_WORD};
      addr_q     <= '0;
      if_data_q  <= ZERO_WORD;
      mem_data_q <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  logic busy;
  assign busy = (state_q != ARB_IDLE);

  assign bus.sram_ce_n_o    = ~busy;
  assign bus.sram_oe_n_o    = ~(state_q == ARB_ACCESS && !req_q.we);
  assign bus.sram_we_n_o    = ~(state_q == ARB_ACCESS &&  req_q.we);
  assign bus.sram_be_n_o    = busy ? req_q.be_n : 4'b1111;
  assign bus.sram_dout_en_o = busy & req_q.we;
  assign bus.sram_addr_o    = addr_q;
  assign bus.sram_wdata_o   = req_q.wdata;

  assign bus.if_ready_o  = (state_q == ARB_HOLD) && (req_q.owner == OWN_IF);
  assign bus.mem_ready_o = (state_q == ARB_HOLD) && (req_q.owner == OWN_MEM);
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.stallreq_o  = (bus.mem_ce_i & ~bus.mem_ready_o) |
                           (bus.if_ce_i  & ~bus.if_ready_o);

  // Byte-offset and above-window address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr_i[31:SRAM_AW+2], bus.if_addr_i[1:0],
                              bus.mem_addr_i[31:SRAM_AW+2], bus.mem_addr_i[1:0]};

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: cycle-by-cycle vector table on a WAIT_CYCLES=1 instance,
// plus a hand sequence on a WAIT_CYCLES=3 instance.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.SRAM_AW(20)) b1 ();
  sram_bus_arbiter_if #(.SRAM_AW(20)) b3 ();

  sram_bus_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(20)) u_w1 (.clk(clk), .rst(rst), .bus(b1));
  sram_bus_arbiter #(.WAIT_CYCLES(3), .SRAM_AW(20)) u_w3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct packed {
    logic        ce_n, oe_n, we_n;
    logic [3:0]  be_n;
    logic        den;
    logic [19:0] addr;
    logic        ifr, memr, stall;
    logic [31:0] if_data, mem_data, wdata;
  } out_t;

  typedef struct packed {
    logic        rst, if_ce;
    logic [31:0] if_addr;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  sel;
    logic [31:0] wdata, rdata;
  } in_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t I(logic r, logic ic, logic [31:0] ia, logic mc, logic mw,
                            logic [31:0] ma, logic [3:0] s, logic [31:0] wd, logic [31:0] rd);
    return '{rst: r, if_ce: ic, if_addr: ia, mem_ce: mc, mem_we: mw,
             mem_addr: ma, sel: s, wdata: wd, rdata: rd};
  endfunction

  function automatic out_t O(logic ce, logic oe, logic we, logic [3:0] be, logic den,
                             logic [19:0] a, logic ifr, logic memr, logic st,
                             logic [31:0] ifd, logic [31:0] md, logic [31:0] wd);
    return '{ce_n: ce, oe_n: oe, we_n: we, be_n: be, den: den, addr: a, ifr: ifr,
             memr: memr, stall: st, if_data: ifd, mem_data: md, wdata: wd};
  endfunction

  task automatic add(input in_t i, input out_t o);
    vecs.push_back('{i: i, o: o});
  endtask

  function automatic out_t sample1();
    return '{ce_n: b1.sram_ce_n_o, oe_n: b1.sram_oe_n_o, we_n: b1.sram_we_n_o,
             be_n: b1.sram_be_n_o, den: b1.sram_dout_en_o, addr: b1.sram_addr_o,
             ifr: b1.if_ready_o, memr: b1.mem_ready_o, stall: b1.stallreq_o,
             if_data: b1.if_data_o, mem_data: b1.mem_data_o, wdata: b1.sram_wdata_o};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF, AB = 32'h00AB00AB, W55 = 32'h55AA55AA;
  localparam logic [31:0] D11 = 32'h11111111, D22 = 32'h22222222, D33 = 32'h33333333;
  localparam logic [31:0] D44 = 32'h44444444, CF = 32'hCAFEF00D;

  in_t  in_idle, iv;
  out_t act;
  int   oe_cnt, rdy_cnt, rdy_cyc;

  initial begin
    in_idle = I(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset state
    add(I(1, 0, 0, 0, 0, 0, 0, 0, 0),           O(1,1,1,4'hF,0,20'h0,0,0,0,0,0,0));
    // single IF read, W=1
    iv = I(0, 1, 32'h10, 0, 0, 0, 0, 0, DB);
    add(iv, O(1,1,1,4'hF,0,20'h0,0,0,1,0,0,0));
    add(iv, O(0,1,1,4'h0,0,20'h4,0,0,1,0,0,0));
    add(iv, O(0,0,1,4'h0,0,20'h4,0,0,1,0,0,0));
    add(iv, O(0,1,1,4'h0,0,20'h4,1,0,0,DB,0,0));
    add(in_idle, O(1,1,1,4'hF,0,20'h4,0,0,0,DB,0,0));
    // byte write, sel=0100
    iv = I(0, 0, 0, 1, 1, 32'h106, 4'b0100, AB, 0);
    add(iv, O(1,1,1,4'hF,0,20'h4,0,0,1,DB,0,0));
    add(iv, O(0,1,1,4'hB,1,20'h41,0,0,1,DB,0,AB));
    add(iv, O(0,1,0,4'hB,1,20'h41,0,0,1,DB,0,AB));
    add(iv, O(0,1,1,4'hB,1,20'h41,0,1,0,DB,0,AB));
    add(in_idle, O(1,1,1,4'hF,0,20'h41,0,0,0,DB,0,AB));
    // contention: MEM first, IF through HOLD->SETUP
    iv = I(0, 1, 32'h30, 1, 0, 32'h20, 4'hF, 0, D11);
    add(iv, O(1,1,1,4'hF,0,20'h41,0,0,1,DB,0,AB));
    add(iv, O(0,1,1,4'h0,0,20'h8,0,0,1,DB,0,0));
    add(iv, O(0,0,1,4'h0,0,20'h8,0,0,1,DB,0,0));
    add(iv, O(0,1,1,4'h0,0,20'h8,0,1,1,DB,D11,0));
    iv = I(0, 1, 32'h30, 0, 0, 0, 0, 0, D22);
    add(iv, O(0,1,1,4'h0,0,20'hC,0,0,1,DB,D11,0));
    add(iv, O(0,0,1,4'h0,0,20'hC,0,0,1,DB,D11,0));
    add(iv, O(0,1,1,4'h0,0,20'hC,1,0,0,D22,D11,0));
    add(in_idle, O(1,1,1,4'hF,0,20'hC,0,0,0,D22,D11,0));
    // write with sel=0: no bytes enabled
    iv = I(0, 0, 0, 1, 1, 32'h200, 4'h0, W55, 0);
    add(iv, O(1,1,1,4'hF,0,20'hC,0,0,1,D22,D11,0));
    add(iv, O(0,1,1,4'hF,1,20'h80,0,0,1,D22,D11,W55));
    add(iv, O(0,1,0,4'hF,1,20'h80,0,0,1,D22,D11,W55));
    add(iv, O(0,1,1,4'hF,1,20'h80,0,1,0,D22,D11,W55));
    add(in_idle, O(1,1,1,4'hF,0,20'h80,0,0,0,D22,D11,W55));
    // MEM drops ce in SETUP, IF pending; MEM address wraps above the window
    add(I(0, 1, 32'h44, 1, 0, 32'hFFF00042, 4'hF, 0, D33), O(1,1,1,4'hF,0,20'h80,0,0,1,D22,D11,W55));
    iv = I(0, 1, 32'h44, 0, 0, 0, 0, 0, D33);
    add(iv, O(0,1,1,4'h0,0,20'hC0010,0,0,1,D22,D11,0));
    add(iv, O(0,0,1,4'h0,0,20'hC0010,0,0,1,D22,D11,0));
    add(iv, O(0,1,1,4'h0,0,20'hC0010,0,1,1,D22,D33,0));
    iv = I(0, 1, 32'h44, 0, 0, 0, 0, 0, D44);
    add(iv, O(0,1,1,4'h0,0,20'h11,0,0,1,D22,D33,0));
    add(iv, O(0,0,1,4'h0,0,20'h11,0,0,1,D22,D33,0));
    add(iv, O(0,1,1,4'h0,0,20'h11,1,0,0,D44,D33,0));
    add(in_idle, O(1,1,1,4'hF,0,20'h11,0,0,0,D44,D33,0));
    // reset during ACCESS of a write, then re-arbitration
    iv = I(0, 0, 0, 1, 1, 32'h8, 4'hF, CF, 0);
    add(iv, O(1,1,1,4'hF,0,20'h11,0,0,1,D44,D33,0));
    add(iv, O(0,1,1,4'h0,1,20'h2,0,0,1,D44,D33,CF));
    add(I(1, 0, 0, 1, 1, 32'h8, 4'hF, CF, 0), O(0,1,0,4'h0,1,20'h2,0,0,1,D44,D33,CF));
    add(iv, O(1,1,1,4'hF,0,20'h0,0,0,1,0,0,0));
    add(iv, O(0,1,1,4'h0,1,20'h2,0,0,1,0,0,CF));
    add(iv, O(0,1,0,4'h0,1,20'h2,0,0,1,0,0,CF));
    add(iv, O(0,1,1,4'h0,1,20'h2,0,1,0,0,0,CF));
    add(in_idle, O(1,1,1,4'hF,0,20'h2,0,0,0,0,0,CF));

    {b1.if_ce_i, b1.if_addr_i, b1.mem_ce_i, b1.mem_we_i, b1.mem_addr_i} = '0;
    {b1.mem_sel_i, b1.mem_data_i, b1.sram_rdata_i} = '0;
    {b3.if_ce_i, b3.if_addr_i, b3.mem_ce_i, b3.mem_we_i, b3.mem_addr_i} = '0;
    {b3.mem_sel_i, b3.mem_data_i, b3.sram_rdata_i} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      rst             = vecs[k].i.rst;
      b1.if_ce_i      = vecs[k].i.if_ce;
      b1.if_addr_i    = vecs[k].i.if_addr;
      b1.mem_ce_i     = vecs[k].i.mem_ce;
      b1.mem_we_i     = vecs[k].i.mem_we;
      b1.mem_addr_i   = vecs[k].i.mem_addr;
      b1.mem_sel_i    = vecs[k].i.sel;
      b1.mem_data_i   = vecs[k].i.wdata;
      b1.sram_rdata_i = vecs[k].i.rdata;
      @(negedge clk);
      act = sample1();
      check($sformatf("row%0d", k), 256'(act), 256'(vecs[k].o));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // WAIT_CYCLES=3 read: oe_n low 3 cycles, ready at cycle 5, data from last ACCESS cycle
    oe_cnt = 0; rdy_cnt = 0; rdy_cyc = -1;
    b3.if_ce_i   = 1'b1;
    b3.if_addr_i = 32'h10;
    for (int c = 0; c < 8; c++) begin
      b3.sram_rdata_i = (c == 4) ? 32'hAABBCCDD : (c == 5 ? 32'h12345678 : 32'h0BAD0BAD);
      @(negedge clk);
      if (!b3.sram_oe_n_o) oe_cnt++;
      if (b3.if_ready_o) begin
        rdy_cnt++;
        rdy_cyc = c;
      end
      if (c == 1) check("w3_setup_addr", 256'(b3.sram_addr_o), 256'(20'h4));
      @(posedge clk);
      #1;
      if (b3.if_ready_o === 1'b0 && rdy_cyc >= 0) b3.if_ce_i = 1'b0;
    end
    check("w3_oe_cycles", 256'(oe_cnt), 256'(3));
    check("w3_ready_cycle", 256'(rdy_cyc), 256'(5));
    check("w3_ready_pulses", 256'(rdy_cnt), 256'(1));
    check("w3_if_data", 256'(b3.if_data_o), 256'(32'hAABBCCDD));
    check("w3_idle_ce_n", 256'(b3.sram_ce_n_o), 256'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one single-port asynchronous word-wide SRAM between two requesters: instruction fetch (IF) and the memory-access stage (MEM).
- Arbitrates between them, then sequences each access as a multi-cycle SRAM read or write: address setup, strobe, hold.
- Requests the pipeline stall until the requester's access has completed.
- Sits between the IF/MEM stages and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 1: number of cycles the strobe (oe_n or we_n) is held low; legal range 1..7.
- SRAM_AW, 20: SRAM word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- if_ce_i  in  1  fetch request; held high until if_ready_o
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched word
- if_ready_o  out  1  one-cycle pulse; if_data_o valid
- mem_ce_i  in  1  data request; held high until mem_ready_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  data byte address
- mem_sel_i  in  4  byte-lane enables (bit n = byte n, little-endian)
- mem_data_i  in  32  store data, already lane-replicated
- mem_data_o  out  32  loaded word
- mem_ready_o  out  1  one-cycle pulse; access complete
- stallreq_o  out  1  pipeline stall request
- sram_addr_o  out  SRAM_AW  word address
- sram_wdata_o  out  32  write data
- sram_rdata_i  in  32  read data
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low
- sram_be_n_o  out  4  byte enables, active-low
- sram_dout_en_o  out  1  drive the data pins (write); the top level builds the tristate

Behaviour:
- Reset (sync): FSM goes to IDLE. Outputs after reset:
  - sram_ce_n/oe_n/we_n = 1; sram_be_n = 4'b1111; sram_dout_en = 0
  - sram_addr = 0; sram_wdata = 0
  - if_data = mem_data = 0; both ready outputs = 0
- Reset mid-transaction aborts at the next edge with all strobes released. The requester still holds ce and re-arbitrates after reset.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE:
  - If mem_ce_i=1, grant MEM. Else if if_ce_i=1, grant IF. MEM always wins simultaneous requests.
  - On grant, register: owner, addr[SRAM_AW+1:2], write flag (IF is always read), be_n (read: 4'b0000; write: ~mem_sel_i), wdata.
  - Go to SETUP.
- SETUP (1 cycle):
  - ce_n = 0; address and be_n driven; oe_n = we_n = 1.
  - dout_en = 1 if write.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - oe_n = 0 for a read; we_n = 0 for a write.
  - On the last ACCESS cycle, a read registers sram_rdata_i into the owner's data output.
- HOLD (1 cycle):
  - Strobes return high; ce_n = 0; address, be_n, wdata and dout_en are held.
  - The owner's ready output is 1 for this cycle only.
  - Next state is IDLE, or directly SETUP if another request is pending (arbitrated exactly as in IDLE, using the same rules).
- Latency from request-seen to ready: WAIT_CYCLES+2 cycles.
  - Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Data outputs hold their last loaded value until the next read by the same owner completes.
- stallreq_o is combinational: (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o).
- Requester drops ce mid-transaction: the access still completes, the ready pulse is issued, and the result is ignored.
- Write with mem_sel_i = 0: the cycle runs normally with be_n = 4'b1111 (no bytes written).
- Address bits [1:0] are ignored; lane selection comes only from sel. Bits above SRAM_AW+1 are ignored (wrap).

Decomposition:
- Shared defines header: state encodings (ARB_IDLE/SETUP/ACCESS/HOLD), owner encodings (OWN_IF/OWN_MEM), plus existing `RegBus, `InstAddrBus, `RstEnable, `ChipEnable, `WriteEnable, `ZeroWord.
- No sub-module needed; the wait counter is inline.

Test Plan:
- Single read, WAIT_CYCLES=1: if_ce=1, addr 0x0000_0010, SRAM returns 0xDEADBEEF -> sram_addr=4, oe_n low 1 cycle, if_ready pulse 3 cycles after request, if_data=0xDEADBEEF.
- Byte write: mem_we=1, sel=4'b0100, addr 0x0000_0106, data 0x00AB00AB... replicated -> be_n=4'b1011, we_n low only in ACCESS, dout_en held through HOLD, mem_ready one pulse.
- Contention: if_ce and mem_ce rise together -> MEM served first (ready at cycle 3), IF served via HOLD->SETUP (ready at cycle 6); stallreq stays high until cycle 6.
- WAIT_CYCLES=3 read -> oe_n low exactly 3 cycles, ready at cycle 5, data sampled on the last ACCESS cycle.
- Reset asserted during ACCESS of a write -> next edge: we_n=1, ce_n=1, be_n=4'b1111, FSM IDLE, no ready pulse.
- Requester drops mem_ce in SETUP -> access completes, mem_ready pulses, next IDLE grant goes to pending IF.
